// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 inverse-cipher controller.
package aes_pkg;
    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } ctrl_state_e;

    typedef logic [127:0] aes_state_t;

    // MSB position of byte s[r][c]; bytes are laid out column-major from bit 127 down.
    function automatic logic [6:0] bidx(input int r, input int c);
        return 7'(127 - 8 * (4 * c + r));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[bidx(r, (c + r) % 4) -: 8] = s[bidx(r, c) -: 8];
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[bidx(r, c) -: 8] = gmul(s[bidx(r, c) -: 8], 8'h0e)
                                   ^ gmul(s[bidx((r + 1) % 4, c) -: 8], 8'h0b)
                                   ^ gmul(s[bidx((r + 2) % 4, c) -: 8], 8'h0d)
                                   ^ gmul(s[bidx((r + 3) % 4, c) -: 8], 8'h09);
        return o;
    endfunction
endpackage

// File: rtl/inv_cipher_ctrl_if.sv
// Block-input, plaintext-output and round-key request signals of the inverse-cipher controller.
interface inv_cipher_ctrl_if;
    // A transfer happens on a rising edge where valid and ready are both high; once valid
    // rises it and its data stay stable until that edge, and ready never waits on valid.
    logic                     in_valid;
    logic                     in_ready;
    logic [127:0]             data_in;
    logic [3:0]               rk_idx;
    logic [127:0]             round_key;
    logic                     out_valid;
    logic                     out_ready;
    logic [127:0]             data_out;
    logic                     busy;
    aes_pkg::ctrl_state_e     dbg_state;

    modport slave (
        input  in_valid, data_in, round_key, out_ready,
        output in_ready, rk_idx, out_valid, data_out, busy, dbg_state
    );

    modport master (
        output in_valid, data_in, round_key, out_ready,
        input  in_ready, rk_idx, out_valid, data_out, busy, dbg_state
    );
endinterface

// File: rtl/inv_round_dp.sv
// One inverse round, combinational; the last round skips InvMixColumns.
module inv_round_dp
    import aes_pkg::*;
(
    input  aes_state_t state_i,
    input  aes_state_t round_key_i,
    input  logic       last_i,
    output aes_state_t state_o
);
    aes_state_t shifted;
    aes_state_t subbed;
    aes_state_t keyed;

    assign shifted = inv_shift_rows(state_i);

    inv_sub_bytes u_isb (
        .data_i (shifted),
        .data_o (subbed)
    );

    assign keyed   = subbed ^ round_key_i;
    assign state_o = last_i ? keyed : inv_mix_columns(keyed);
endmodule

// File: rtl/inv_sub_bytes.sv
// InvSubBytes on all 16 state bytes: inverse affine map followed by GF(2^8) inversion.
module inv_sub_bytes
    import aes_pkg::*;
(
    input  aes_state_t data_i,
    output aes_state_t data_o
);
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        logic [7:0] r;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        // Raise t to 254 (its inverse); the chain leaves zero at zero.
        r = t;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), t);
        return gmul(r, r);
    endfunction

    always_comb begin
        data_o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                data_o[bidx(r, c) -: 8] = inv_sbox(data_i[bidx(r, c) -: 8]);
    end
endmodule

// File: rtl/inv_cipher_ctrl.sv
// Iterative AES-128 inverse-cipher controller: one round per cycle, round keys fetched by index.
module inv_cipher_ctrl
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    inv_cipher_ctrl_if.slave bus
);
    ctrl_state_e state_q, state_d;
    aes_state_t  blk_q, blk_d;
    aes_state_t  dp_next;
    logic [3:0]  rnd_q, rnd_d;

    inv_round_dp u_dp (
        .state_i     (blk_q),
        .round_key_i (bus.round_key),
        .last_i      (state_q == ST_FINAL),
        .state_o     (dp_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            blk_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        rnd_d   = rnd_q;
        case (state_q)
            ST_IDLE: begin
                // Initial AddRoundKey uses key 10, which rk_idx already requests in IDLE.
                if (bus.in_valid) begin
                    state_d = ST_ROUND;
                    blk_d   = bus.data_in ^ bus.round_key;
                    rnd_d   = 4'(NR - 1);
                end
            end
            ST_ROUND: begin
                blk_d = dp_next;
                if (rnd_q == 4'd1) state_d = ST_FINAL;
                else               rnd_d   = rnd_q - 4'd1;
            end
            ST_FINAL: begin
                blk_d   = dp_next;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        bus.rk_idx    = 4'd0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                bus.rk_idx   = 4'(NR);
            end
            ST_ROUND: bus.rk_idx    = rnd_q;
            ST_FINAL: bus.rk_idx    = 4'd0;
            ST_DONE:  bus.out_valid = 1'b1;
            default:  bus.busy      = 1'b1;
        endcase
    end

    assign bus.data_out  = blk_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// Directed bench for inv_cipher_ctrl using FIPS-197 known-answer blocks and a key-schedule model.
module tb_inv_cipher_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [127:0] rk_tab [0:10];

    inv_cipher_ctrl_if bus ();

    inv_cipher_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.round_key = (bus.rk_idx <= 4'd10) ? rk_tab[bus.rk_idx] : 128'h0;

    // ---------------- clock / reset helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- key-schedule model ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = m_mul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])}
                    ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int j = 0; j <= 10; j++) rk_tab[j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
    endtask

    // ---------------- driver ----------------
    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt, input string tag);
        int n;
        bus.data_in   = ct;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, 128'(bus.in_ready), 128'd1);
        tick();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'd11);
        chk({tag, "_pt"}, bus.data_out, pt);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_idle"}, 128'(bus.in_ready), 128'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int ov_seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in   = '0;
        load_key(K_C1);
        chk("ks_c1_rk10", rk_tab[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // reset values
        tick();
        tick();
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_rk_idx", 128'(bus.rk_idx), 128'd10);
        chk("rst_data_out", bus.data_out, 128'h0);
        chk("rst_state", 128'(bus.dbg_state), 128'(ST_IDLE));
        rst = 1'b0;
        tick();

        // FIPS-197 C.1 with cycle-exact rk_idx sequence
        bus.data_in  = C_C1;
        bus.in_valid = 1'b1;
        chk("c1_rk_idle", 128'(bus.rk_idx), 128'd10);
        chk("c1_rdy", 128'(bus.in_ready), 128'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int k = 9; k >= 1; k--) begin
            chk($sformatf("c1_rk_r%0d", k), 128'(bus.rk_idx), 128'(k));
            chk($sformatf("c1_ov_r%0d", k), 128'(bus.out_valid), 128'd0);
            tick();
        end
        chk("c1_rk_final", 128'(bus.rk_idx), 128'd0);
        chk("c1_state_final", 128'(bus.dbg_state), 128'(ST_FINAL));
        chk("c1_ov_final", 128'(bus.out_valid), 128'd0);
        tick();
        chk("c1_ov_done", 128'(bus.out_valid), 128'd1);
        chk("c1_pt", bus.data_out, P_C1);
        chk("c1_rk_done", 128'(bus.rk_idx), 128'd0);
        chk("c1_busy_done", 128'(bus.busy), 128'd1);
        chk("c1_rdy_done", 128'(bus.in_ready), 128'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("c1_back_idle_rdy", 128'(bus.in_ready), 128'd1);
        chk("c1_back_idle_ov", 128'(bus.out_valid), 128'd0);
        chk("c1_back_idle_busy", 128'(bus.busy), 128'd0);

        // FIPS-197 App. B
        load_key(K_B);
        chk("ks_b_rk10", rk_tab[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_block(C_B, P_B, "b");

        // backpressure: hold DONE 20 cycles while a second block is offered
        bus.data_in   = C_B;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("bp_lat", 128'(n), 128'd11);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = (i % 3 == 0);
            bus.data_in  = C_C1;
            chk($sformatf("bp_hold_%0d", i), bus.data_out, P_B);
            chk($sformatf("bp_rdy_%0d", i), 128'(bus.in_ready), 128'd0);
            chk($sformatf("bp_ov_%0d", i), 128'(bus.out_valid), 128'd1);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_hold_last", bus.data_out, P_B);
        tick();
        bus.out_ready = 1'b0;
        chk("bp_idle_rdy", 128'(bus.in_ready), 128'd1);
        chk("bp_idle_ov", 128'(bus.out_valid), 128'd0);
        tick();
        chk("bp_not_queued_busy", 128'(bus.busy), 128'd0);
        chk("bp_not_queued_state", 128'(bus.dbg_state), 128'(ST_IDLE));
        run_block(C_B, P_B, "bp_next");

        // back-to-back: in_valid and out_ready held high
        load_key(K_C1);
        bus.data_in   = C_C1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        chk("b2b_rdy1", 128'(bus.in_ready), 128'd1);
        tick();
        bus.data_in = C_B;
        n = 1;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("b2b_lat1", 128'(n), 128'd11);
        chk("b2b_pt1", bus.data_out, P_C1);
        chk("b2b_rdy_done", 128'(bus.in_ready), 128'd0);
        load_key(K_B);
        tick();
        chk("b2b_rdy2_at12", 128'(bus.in_ready), 128'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_busy2", 128'(bus.busy), 128'd1);
        n = 1;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("b2b_lat2", 128'(n), 128'd11);
        chk("b2b_pt2", bus.data_out, P_B);
        tick();
        bus.out_ready = 1'b0;
        chk("b2b_end_idle", 128'(bus.in_ready), 128'd1);

        // reset in the middle of a decryption, competing with in_valid/out_ready
        load_key(K_C1);
        bus.data_in  = C_C1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_busy_before", 128'(bus.busy), 128'd1);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("mid_rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("mid_rst_busy", 128'(bus.busy), 128'd0);
        chk("mid_rst_rk_idx", 128'(bus.rk_idx), 128'd10);
        chk("mid_rst_data_out", bus.data_out, 128'h0);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.out_valid) ov_seen++;
        end
        chk("mid_no_out_valid", 128'(ov_seen), 128'd0);
        run_block(C_C1, P_C1, "mid_c1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
